// File: rtl/wb_stage_reg.sv
// MEM/WB stage register feeding the 4-way writeback source mux, with valid/ready handshake and flush.
// Define SKID_BUFFER_EN for a skid entry and registered InReady; the default build uses combinational ready.
module wb_stage_reg #(
    parameter int NrOfBits = 32
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Flush,
    input  logic                InValid,
    output logic                InReady,
    input  logic [NrOfBits-1:0] InAlu,
    input  logic [NrOfBits-1:0] InMem,
    input  logic [NrOfBits-1:0] InPcPlus4,
    input  logic [NrOfBits-1:0] InImm,
    input  logic [1:0]          InSel,
    input  logic [4:0]          InRd,
    input  logic                InRegWrite,
    output logic                OutValid,
    input  logic                OutReady,
    output logic [NrOfBits-1:0] MuxIn_0,
    output logic [NrOfBits-1:0] MuxIn_1,
    output logic [NrOfBits-1:0] MuxIn_2,
    output logic [NrOfBits-1:0] MuxIn_3,
    output logic [1:0]          Sel,
    output logic [4:0]          OutRd,
    output logic                OutRegWrite
);

    typedef struct packed {
        logic [NrOfBits-1:0] mux3;
        logic [NrOfBits-1:0] mux2;
        logic [NrOfBits-1:0] mux1;
        logic [NrOfBits-1:0] mux0;
        logic [1:0]          sel;
        logic [4:0]          rd;
        logic                regwrite;
    } entry_t;

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

    entry_t w_in_entry;
    entry_t r_main;
    state_t r_state;
    logic   r_valid;
    logic   w_in_fire;

    assign w_in_entry = '{mux3: InImm, mux2: InPcPlus4, mux1: InMem, mux0: InAlu,
                          sel: InSel, rd: InRd, regwrite: InRegWrite};

    assign OutValid    = r_valid;
    assign MuxIn_0     = r_main.mux0;
    assign MuxIn_1     = r_main.mux1;
    assign MuxIn_2     = r_main.mux2;
    assign MuxIn_3     = r_main.mux3;
    assign Sel         = r_main.sel;
    assign OutRd       = r_main.rd;
    assign OutRegWrite = r_main.regwrite & r_valid;

`ifdef SKID_BUFFER_EN
    entry_t r_skid;
    logic   r_in_ready;

    assign InReady   = r_in_ready;
    assign w_in_fire = InValid & r_in_ready;

    always_ff @(posedge Clock or posedge Reset) begin
        // NOTE: data registers are reset too, because every output must read 0 while Reset is high.
        if (Reset) begin
            r_state    <= ST_EMPTY;
            r_main     <= '0;
            r_skid     <= '0;
            r_valid    <= 1'b0;
            r_in_ready <= 1'b0;
        end else if (Flush) begin
            r_state    <= ST_EMPTY;
            r_valid    <= 1'b0;
            r_in_ready <= 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    r_in_ready <= 1'b1;
                    if (w_in_fire) begin
                        r_main  <= w_in_entry;
                        r_valid <= 1'b1;
                        r_state <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && OutReady) begin
                        r_main <= w_in_entry;
                    end else if (w_in_fire) begin
                        // Downstream stalled: park the new entry behind main and close the input.
                        r_skid     <= w_in_entry;
                        r_state    <= ST_TWO;
                        r_in_ready <= 1'b0;
                    end else if (OutReady) begin
                        r_valid <= 1'b0;
                        r_state <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (OutReady) begin
                        r_main     <= r_skid;
                        r_state    <= ST_ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_EMPTY;
                    r_valid    <= 1'b0;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end
`else
    logic r_init;
    logic w_in_ready;

    // r_init holds InReady low until the first edge after Reset releases.
    assign w_in_ready = r_init & (~r_valid | OutReady);
    assign InReady    = w_in_ready;
    assign w_in_fire  = InValid & w_in_ready;

    always_ff @(posedge Clock or posedge Reset) begin
        // NOTE: data registers are reset too, because every output must read 0 while Reset is high.
        if (Reset) begin
            r_state <= ST_EMPTY;
            r_main  <= '0;
            r_valid <= 1'b0;
            r_init  <= 1'b0;
        end else begin
            r_init <= 1'b1;
            if (Flush) begin
                r_state <= ST_EMPTY;
                r_valid <= 1'b0;
            end else begin
                case (r_state)
                    ST_EMPTY: begin
                        if (w_in_fire) begin
                            r_main  <= w_in_entry;
                            r_valid <= 1'b1;
                            r_state <= ST_ONE;
                        end
                    end
                    ST_ONE: begin
                        if (w_in_fire) begin
                            r_main <= w_in_entry;
                        end else if (OutReady) begin
                            r_valid <= 1'b0;
                            r_state <= ST_EMPTY;
                        end
                    end
                    default: begin
                        r_state <= ST_EMPTY;
                        r_valid <= 1'b0;
                    end
                endcase
            end
        end
    end
`endif

endmodule
